// File: rtl/i281_loader_pkg.sv
// rtl/i281_loader_pkg.sv - shared types and constants for the i281 code loader
//
// Purpose: FSM state encoding, default frame header byte, i281 instruction
// field positions and a helper that packs a received byte pair into a word.
// Ports: none (package).
package i281_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COUNT   = 3'd1,
      ST_DATA_HI = 3'd2,
      ST_DATA_LO = 3'd3,
      ST_CHECK   = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RA_MSB  = 11;
   localparam int RA_LSB  = 10;
   localparam int RB_MSB  = 9;
   localparam int RB_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   // High byte carries opcode/rA/rB, low byte carries the immediate.
   function automatic logic [15:0] make_instr(input logic [7:0] hi, input logic [7:0] lo);
      logic [15:0] w;
      w = '0;
      w[OPC_MSB:OPC_LSB] = hi[7:4];
      w[RA_MSB:RA_LSB]   = hi[3:2];
      w[RB_MSB:RB_LSB]   = hi[1:0];
      w[IMM_MSB:IMM_LSB] = lo;
      return w;
   endfunction

endpackage

// File: rtl/i281_load_csum.sv
// rtl/i281_load_csum.sv - 8-bit wrap-around checksum accumulator
//
// Purpose: accumulates frame data bytes modulo 256 and compares the running
// sum against the received checksum byte.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       zero the sum (takes priority over add)
//   add       add din to the sum
//   din       byte to add / byte to compare against
//   match     current sum equals din
module i281_load_csum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       add,
   input  logic [7:0] din,
   output logic       match
);

   logic [7:0] sum_q;
   logic [7:0] sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (add) begin
         sum_d = sum_q + din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign match = (sum_q == din);

endmodule

// File: rtl/i281_code_loader.sv
// rtl/i281_code_loader.sv - framed byte stream to i281 code memory writer
//
// Purpose: parses SYNC, N, 2N data bytes (high first), CSUM from the host
// link, writes each 16-bit word to the code bank and reports the outcome.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    host byte stream; transfer when in_valid && in_ready
//   in_ready            low only in the result (DONE/ERROR) cycle and in reset
//   wr_en/wr_addr/wr_data  one-cycle code memory write
//   cpu_hold            high while a frame is in flight
//   load_ok/load_err    one-cycle result pulses
module i281_code_loader
   import i281_loader_pkg::*;
#(
   parameter int         CODE_WORDS = 16,
   parameter int         ADDR_W     = 4,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              cpu_hold,
   output logic              load_ok,
   output logic              load_err
);

   localparam int         CNT_W = $clog2(CODE_WORDS + 1);
   localparam logic [7:0] MAX_N = 8'(CODE_WORDS);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;     // words received so far in this frame
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          hi_q, hi_d;
   logic                wr_en_q, wr_en_d;
   logic [15:0]         wr_data_q, wr_data_d;
   logic                csum_clr, csum_add, csum_match;
   logic                accept;

   assign accept = in_valid && in_ready;

   i281_load_csum u_csum (
      .clk   (clk),
      .rst   (rst),
      .clr   (csum_clr),
      .add   (csum_add),
      .din   (in_data),
      .match (csum_match)
   );

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      hi_d      = hi_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      csum_clr  = 1'b0;
      csum_add  = 1'b0;

      // Advance the address once the write has gone out, except after the
      // last word so wr_addr stays within 0..N-1.
      if (wr_en_q && (cnt_q < n_q)) begin
         addr_d = addr_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept && (in_data == SYNC_BYTE)) begin
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (accept) begin
               if ((in_data == 8'd0) || (in_data > MAX_N)) begin
                  state_d = ST_ERROR;
               end else begin
                  n_d      = in_data[CNT_W-1:0];
                  cnt_d    = '0;
                  addr_d   = '0;
                  csum_clr = 1'b1;
                  state_d  = ST_DATA_HI;
               end
            end
         end
         ST_DATA_HI: begin
            if (accept) begin
               hi_d     = in_data;
               csum_add = 1'b1;
               state_d  = ST_DATA_LO;
            end
         end
         ST_DATA_LO: begin
            if (accept) begin
               csum_add  = 1'b1;
               wr_en_d   = 1'b1;
               wr_data_d = make_instr(hi_q, in_data);
               cnt_d     = cnt_q + 1'b1;
               state_d   = ((cnt_q + 1'b1) == n_q) ? ST_CHECK : ST_DATA_HI;
            end
         end
         ST_CHECK: begin
            if (accept) begin
               state_d = csum_match ? ST_DONE : ST_ERROR;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         n_q       <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         hi_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         hi_q      <= hi_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Gated by rst so the link sees not-ready for the whole reset interval.
   assign in_ready = !rst && (state_q != ST_DONE) && (state_q != ST_ERROR);
   assign cpu_hold = (state_q == ST_COUNT) || (state_q == ST_DATA_HI) ||
                     (state_q == ST_DATA_LO) || (state_q == ST_CHECK);
   assign load_ok  = (state_q == ST_DONE);
   assign load_err = (state_q == ST_ERROR);
   assign wr_en    = wr_en_q;
   assign wr_addr  = addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i281_code_loader.sv
// tb/tb_i281_code_loader.sv - self-checking bench for i281_code_loader
module tb_i281_code_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        cpu_hold;
   logic        load_ok;
   logic        load_err;

   i281_code_loader #(.CODE_WORDS(16), .ADDR_W(4), .SYNC_BYTE(8'hA5)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .load_ok  (load_ok),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] RES_OK  = 2'b10;
   localparam logic [1:0] RES_ERR = 2'b01;

   // Expectation tables: written only by the driver, read by the checker.
   logic [3:0]  exp_addr [64];
   logic [15:0] exp_data [64];
   int          exp_wr_n = 0;
   logic [1:0]  exp_res [16];
   int          exp_res_n = 0;
   int          frames_started = 0;
   int          timeouts = 0;
   bit          test_done = 1'b0;
   logic [7:0]  csum_t1, csum_t4, csum_t6;
   logic [15:0] fw [16];

   // Checker-owned state.
   int n_checks = 0;
   int n_fail = 0;
   int rd_wr = 0;
   int rd_res = 0;
   int frames_ended = 0;
   int wr_seen = 0;
   int res_seen = 0;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always begin
      @(negedge clk or posedge rst);
      #1;
      if (test_done) begin
         chk(rd_wr == exp_wr_n, "all_writes_seen", rd_wr, exp_wr_n);
         chk(rd_res == exp_res_n, "all_results_seen", rd_res, exp_res_n);
         chk(timeouts == 0, "handshake_timeouts", timeouts, 0);
         chk(wr_seen == 23, "total_writes", wr_seen, 23);
         chk(res_seen == 7, "total_results", res_seen, 7);
         chk(csum_t1 == 8'h64, "model_csum_t1", csum_t1, 8'h64);
         chk(csum_t4 == 8'h70, "model_csum_t4", csum_t4, 8'h70);
         chk(csum_t6 == 8'h46, "model_csum_t6", csum_t6, 8'h46);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end else if (rst) begin
         chk({in_ready, wr_en, cpu_hold, load_ok, load_err} == 5'b0, "reset_ctrl_zero",
             {in_ready, wr_en, cpu_hold, load_ok, load_err}, 0);
         chk({wr_addr, wr_data} == 20'h0, "reset_wr_zero", {wr_addr, wr_data}, 0);
      end else begin
         logic pulse;
         logic exp_hold;
         pulse    = load_ok | load_err;
         exp_hold = (frames_started > frames_ended) && !pulse;
         chk(in_ready == !pulse, "in_ready", in_ready, !pulse);
         chk(cpu_hold == exp_hold, "cpu_hold", cpu_hold, exp_hold);
         if (wr_en) begin
            wr_seen++;
            if (rd_wr >= exp_wr_n) begin
               chk(1'b0, "unexpected_write", {wr_addr, wr_data}, 0);
            end else begin
               chk(wr_addr == exp_addr[rd_wr], "wr_addr", wr_addr, exp_addr[rd_wr]);
               chk(wr_data == exp_data[rd_wr], "wr_data", wr_data, exp_data[rd_wr]);
               rd_wr++;
            end
         end
         if (pulse) begin
            res_seen++;
            frames_ended++;
            if (rd_res >= exp_res_n) begin
               chk(1'b0, "unexpected_result", {load_ok, load_err}, 0);
            end else begin
               chk({load_ok, load_err} == exp_res[rd_res], "result",
                   {load_ok, load_err}, exp_res[rd_res]);
               rd_res++;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit is_sync);
      int guard;
      guard = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) timeouts++;
      @(posedge clk);
      if (is_sync) frames_started++;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic push_wr(input int a, input logic [15:0] d);
      exp_addr[exp_wr_n] = 4'(a);
      exp_data[exp_wr_n] = d;
      exp_wr_n++;
   endtask

   task automatic push_res(input logic [1:0] r);
      exp_res[exp_res_n] = r;
      exp_res_n++;
   endtask

   // Sends a full frame of fw[0..n-1]; csum_xor != 0 corrupts the checksum.
   task automatic send_frame(input int n, input logic [7:0] csum_xor, input bit toggle,
                             output logic [7:0] csum);
      csum = 8'h00;
      for (int k = 0; k < n; k++) begin
         csum = csum + fw[k][15:8] + fw[k][7:0];
         push_wr(k, fw[k]);
      end
      push_res((csum_xor == 8'h00) ? RES_OK : RES_ERR);
      send_byte(8'hA5, 1'b1);
      if (toggle) gap(1);
      send_byte(8'(n), 1'b0);
      for (int k = 0; k < n; k++) begin
         if (toggle) gap(1);
         send_byte(fw[k][15:8], 1'b0);
         if (toggle) gap(1);
         send_byte(fw[k][7:0], 1'b0);
      end
      if (toggle) gap(1);
      send_byte(csum ^ csum_xor, 1'b0);
   endtask

   initial begin
      logic [7:0] cs;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1 then 2 back to back: in_valid stays high through the DONE cycle.
      fw[0] = 16'h3000; fw[1] = 16'h3400;
      send_frame(2, 8'h00, 1'b0, csum_t1);
      fw[0] = 16'h3000;
      send_frame(1, 8'h55, 1'b0, cs);
      gap(2);

      // 3: bad counts, then trailing bytes ignored in IDLE.
      push_res(RES_ERR);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b0);
      push_res(RES_ERR);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h11, 1'b0);
      send_byte(8'h30, 1'b0);
      send_byte(8'h00, 1'b0);
      gap(3);

      // 4: full 16-word frame with in_valid toggling.
      for (int k = 0; k < 16; k++) fw[k] = {8'hF0 + 8'(k), 8'(17 * k)};
      send_frame(16, 8'h00, 1'b1, csum_t4);
      gap(2);

      // 5: reset after three data bytes, then a fresh frame.
      push_wr(0, 16'h1122);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      #1 rst = 1'b1;
      in_valid = 1'b0;
      frames_started = frames_ended;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fw[0] = 16'hABCD; fw[1] = 16'h0102;
      send_frame(2, 8'h00, 1'b0, cs);
      gap(2);

      // 6: idle noise before a frame.
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'h5A, 1'b0);
      fw[0] = 16'h1234;
      send_frame(1, 8'h00, 1'b0, csum_t6);
      gap(4);
      test_done = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
